// File: rtl/clap_command_sequencer.sv
// rtl/clap_command_sequencer.sv - clap gesture sequencer driving light/fan toggles
//
// Purpose: re-arms a sticky clap detector after each clap, ignores claps during
// a refractory gap, counts claps inside a timeout window and decodes the count
// into a light/fan command when the window closes (or on the third clap).
//
// Ports:
//   clk           in   system clock, rising edge
//   enable        in   asynchronous active-low reset
//   clap_detected in   sticky clap flag from the detector
//   det_enable    out  active-low reset/enable to the detector (low = clear)
//   cmd_valid     out  one-cycle pulse when a gesture is decoded
//   cmd_code      out  clap count of the last decoded gesture (1..3)
//   clap_count    out  claps counted in the current gesture
//   light_on      out  light state
//   fan_on        out  fan state
//   busy          out  high whenever the sequencer is not idle
module clap_command_sequencer #(
  parameter int REFRACT_CYCLES = 5000000,
  parameter int WINDOW_CYCLES  = 25000000,
  parameter int TIMER_W        = 25
) (
  input  logic       clk,
  input  logic       enable,
  input  logic       clap_detected,
  output logic       det_enable,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic [1:0] clap_count,
  output logic       light_on,
  output logic       fan_on,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REARM  = 3'd1,
    S_GAP    = 3'd2,
    S_WINDOW = 3'd3,
    S_DECODE = 3'd4
  } state_e;

  localparam logic [TIMER_W-1:0] REFRACT_LAST = TIMER_W'(REFRACT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WINDOW_LAST  = TIMER_W'(WINDOW_CYCLES - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         count_q, count_d;
  logic               det_enable_q, det_enable_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [1:0]         cmd_code_q, cmd_code_d;
  logic               light_q, light_d;
  logic               fan_q, fan_d;
  logic               busy_q, busy_d;

  // Next-state, timer and clap counter.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (clap_detected) begin
          state_d = S_REARM;
          count_d = 2'd1;
        end
      end
      S_REARM: begin
        timer_d = '0;
        state_d = (count_q == 2'd3) ? S_DECODE : S_GAP;
      end
      S_GAP: begin
        if (timer_q == REFRACT_LAST) begin
          state_d = S_WINDOW;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WINDOW: begin
        // A clap on the final window cycle still counts: it is tested first.
        if (clap_detected) begin
          state_d = S_REARM;
          count_d = (count_q == 2'd3) ? 2'd3 : count_q + 2'd1;
        end else if (timer_q == WINDOW_LAST) begin
          state_d = S_DECODE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DECODE: begin
        state_d = S_IDLE;
        count_d = 2'd0;
      end
      default: begin
        state_d = S_IDLE;
        count_d = 2'd0;
        timer_d = '0;
      end
    endcase
  end

  // Outputs are registered from the next state, so they line up with the
  // state register: det_enable drops in the same cycle REARM is entered.
  always_comb begin
    det_enable_d = (state_d != S_REARM) && (state_d != S_DECODE);
    cmd_valid_d  = (state_d == S_DECODE);
    busy_d       = (state_d != S_IDLE);
    cmd_code_d   = cmd_code_q;
    light_d      = light_q;
    fan_d        = fan_q;
    if (cmd_valid_d) begin
      cmd_code_d = count_d;
      unique case (count_d)
        2'd1:    light_d = ~light_q;
        2'd2:    fan_d   = ~fan_q;
        2'd3: begin
          light_d = 1'b0;
          fan_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      count_q      <= 2'd0;
      det_enable_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= 2'd0;
      light_q      <= 1'b0;
      fan_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      count_q      <= count_d;
      det_enable_q <= det_enable_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_code_q   <= cmd_code_d;
      light_q      <= light_d;
      fan_q        <= fan_d;
      busy_q       <= busy_d;
    end
  end

  assign det_enable = det_enable_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign clap_count = count_q;
  assign light_on   = light_q;
  assign fan_on     = fan_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_clap_command_sequencer.sv
// tb/tb_clap_command_sequencer.sv - self-checking bench for clap_command_sequencer
module tb_clap_command_sequencer;

  logic       clk;
  logic       enable;
  logic       clap_detected;
  logic       det_enable;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic [1:0] clap_count;
  logic       light_on;
  logic       fan_on;
  logic       busy;

  clap_command_sequencer #(
    .REFRACT_CYCLES(4),
    .WINDOW_CYCLES (16),
    .TIMER_W       (5)
  ) dut (
    .clk          (clk),
    .enable       (enable),
    .clap_detected(clap_detected),
    .det_enable   (det_enable),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .clap_count   (clap_count),
    .light_on     (light_on),
    .fan_on       (fan_on),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] code;
    logic       light;
    logic       fan;
  } cmd_t;

  cmd_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   pulses = 0;
  logic exp_light = 1'b0;
  logic exp_fan   = 1'b0;

  always @(negedge clk) if (cmd_valid === 1'b1) pulses++;

  // Expected command for a gesture of n claps, from the bench's own light/fan model.
  task automatic push_expect(input logic [1:0] n);
    cmd_t e;
    case (n)
      2'd1: exp_light = ~exp_light;
      2'd2: exp_fan   = ~exp_fan;
      default: begin exp_light = 1'b0; exp_fan = 1'b0; end
    endcase
    e.code = n; e.light = exp_light; e.fan = exp_fan;
    sb.push_back(e);
  endtask

  // Raise clap_detected at a negedge until det_enable is seen low; returns at that negedge.
  task automatic do_clap(input bit hold, output bit ok);
    ok = 1'b0;
    clap_detected = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (det_enable === 1'b0) begin ok = 1'b1; break; end
    end
    if (!hold) clap_detected = 1'b0;
  endtask

  task automatic wait_cmd(input int max, output bit got, output int cyc);
    got = 1'b0; cyc = 0;
    while (cyc < max) begin
      @(negedge clk);
      cyc++;
      if (cmd_valid === 1'b1) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    enable = 1'b0; clap_detected = 1'b0;
    #3;
    n_cmp++;
    if ({det_enable, cmd_valid, cmd_code, clap_count, light_on, fan_on, busy} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 000000000",
               {det_enable, cmd_valid, cmd_code, clap_count, light_on, fan_on, busy});
    end
    repeat (2) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (det_enable !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: det_enable=%b busy=%b required 1 0", det_enable, busy);
    end
  endtask

  task automatic test_single;
    bit ok, got; int cyc; cmd_t e;
    push_expect(2'd1);
    do_clap(1'b0, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL single_rearm: det_enable never fell"); end
    n_cmp++;
    if (clap_count !== 2'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_count: clap_count=%0d busy=%b required 1 1", clap_count, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (det_enable !== 1'b1) begin
      n_fail++; $display("FAIL single_pulse_width: det_enable=%b required 1", det_enable);
    end
    wait_cmd(40, got, cyc);
    n_cmp++;
    if (!got || cyc != 20) begin
      n_fail++; $display("FAIL single_latency: got=%0d cycles=%0d required 1 20", got, cyc);
    end
    if (got) begin
      e = sb.pop_front();
      n_cmp++;
      if ({cmd_code, light_on, fan_on} !== {e.code, e.light, e.fan}) begin
        n_fail++;
        $display("FAIL single_cmd: code/light/fan=%0d/%b/%b required %0d/%b/%b",
                 cmd_code, light_on, fan_on, e.code, e.light, e.fan);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: cmd_valid=%b busy=%b required 0 0", cmd_valid, busy);
    end
  endtask

  task automatic test_double;
    bit ok, got; int cyc; cmd_t e;
    push_expect(2'd2);
    do_clap(1'b0, ok);
    repeat (10) @(negedge clk);           // WINDOW, timer = 5
    do_clap(1'b0, ok);
    n_cmp++;
    if (!ok || clap_count !== 2'd2) begin
      n_fail++; $display("FAIL double_second: ok=%0d clap_count=%0d required 1 2", ok, clap_count);
    end
    wait_cmd(40, got, cyc);
    n_cmp++;
    if (!got || cyc != 21) begin
      n_fail++; $display("FAIL double_latency: got=%0d cycles=%0d required 1 21", got, cyc);
    end
    if (got) begin
      e = sb.pop_front();
      n_cmp++;
      if ({cmd_code, light_on, fan_on} !== {e.code, e.light, e.fan}) begin
        n_fail++;
        $display("FAIL double_cmd: code/light/fan=%0d/%b/%b required %0d/%b/%b",
                 cmd_code, light_on, fan_on, e.code, e.light, e.fan);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_triple;
    bit ok, got; int cyc; cmd_t e;
    push_expect(2'd3);
    do_clap(1'b0, ok);
    repeat (6) @(negedge clk);
    do_clap(1'b0, ok);
    repeat (6) @(negedge clk);
    do_clap(1'b0, ok);
    n_cmp++;
    if (!ok || clap_count !== 2'd3) begin
      n_fail++; $display("FAIL triple_third: ok=%0d clap_count=%0d required 1 3", ok, clap_count);
    end
    wait_cmd(40, got, cyc);
    n_cmp++;
    if (!got || cyc != 1) begin
      n_fail++; $display("FAIL triple_latency: got=%0d cycles=%0d required 1 1", got, cyc);
    end
    if (got) begin
      e = sb.pop_front();
      n_cmp++;
      if ({cmd_code, light_on, fan_on} !== {e.code, e.light, e.fan}) begin
        n_fail++;
        $display("FAIL triple_cmd: code/light/fan=%0d/%b/%b required %0d/%b/%b",
                 cmd_code, light_on, fan_on, e.code, e.light, e.fan);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_refractory;
    bit ok, got; int cyc; cmd_t e; int bad;
    push_expect(2'd2);
    do_clap(1'b1, ok);                    // keep clap_detected high through GAP
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (clap_count !== 2'd1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++; $display("FAIL refract_hold: %0d cycles with clap_count!=1 required 0", bad);
    end
    @(negedge clk);
    clap_detected = 1'b0;
    n_cmp++;
    if (clap_count !== 2'd2 || det_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL refract_window_entry: clap_count=%0d det_enable=%b required 2 0",
               clap_count, det_enable);
    end
    wait_cmd(40, got, cyc);
    n_cmp++;
    if (!got) begin n_fail++; $display("FAIL refract_cmd_timeout: no cmd_valid required one"); end
    else begin
      e = sb.pop_front();
      n_cmp++;
      if ({cmd_code, light_on, fan_on} !== {e.code, e.light, e.fan}) begin
        n_fail++;
        $display("FAIL refract_cmd: code/light/fan=%0d/%b/%b required %0d/%b/%b",
                 cmd_code, light_on, fan_on, e.code, e.light, e.fan);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_boundary;
    bit ok, got; int cyc; cmd_t e;
    push_expect(2'd2);
    do_clap(1'b0, ok);
    repeat (20) @(negedge clk);           // WINDOW, timer = 15
    clap_detected = 1'b1;
    @(negedge clk);
    clap_detected = 1'b0;
    n_cmp++;
    if (cmd_valid !== 1'b0 || clap_count !== 2'd2 || det_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL boundary_clap_wins: cmd_valid=%b clap_count=%0d det_enable=%b required 0 2 0",
               cmd_valid, clap_count, det_enable);
    end
    wait_cmd(40, got, cyc);
    n_cmp++;
    if (!got || cyc != 21) begin
      n_fail++; $display("FAIL boundary_latency: got=%0d cycles=%0d required 1 21", got, cyc);
    end
    if (got) begin
      e = sb.pop_front();
      n_cmp++;
      if ({cmd_code, light_on, fan_on} !== {e.code, e.light, e.fan}) begin
        n_fail++;
        $display("FAIL boundary_cmd: code/light/fan=%0d/%b/%b required %0d/%b/%b",
                 cmd_code, light_on, fan_on, e.code, e.light, e.fan);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    bit ok, got; int cyc; cmd_t e; int snap;
    if (!exp_light) begin                 // make sure something is on before the reset
      push_expect(2'd1);
      do_clap(1'b0, ok);
      wait_cmd(40, got, cyc);
      if (got) e = sb.pop_front();
      @(negedge clk);
    end
    do_clap(1'b0, ok);
    repeat (6) @(negedge clk);
    do_clap(1'b0, ok);
    repeat (7) @(negedge clk);            // WINDOW with clap_count = 2
    #2 enable = 1'b0;
    #1;
    n_cmp++;
    if ({det_enable, cmd_valid, cmd_code, clap_count, light_on, fan_on, busy} !== 9'b0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %b required 000000000",
               {det_enable, cmd_valid, cmd_code, clap_count, light_on, fan_on, busy});
    end
    exp_light = 1'b0; exp_fan = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    snap = pulses;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (pulses != snap) begin
      n_fail++; $display("FAIL async_no_cmd: %0d cmd_valid pulses required 0", pulses - snap);
    end
    push_expect(2'd1);
    do_clap(1'b0, ok);
    n_cmp++;
    if (!ok || clap_count !== 2'd1) begin
      n_fail++; $display("FAIL async_restart: ok=%0d clap_count=%0d required 1 1", ok, clap_count);
    end
    wait_cmd(40, got, cyc);
    n_cmp++;
    if (!got) begin n_fail++; $display("FAIL async_cmd_timeout: no cmd_valid required one"); end
    else begin
      e = sb.pop_front();
      n_cmp++;
      if ({cmd_code, light_on, fan_on} !== {e.code, e.light, e.fan}) begin
        n_fail++;
        $display("FAIL async_cmd: code/light/fan=%0d/%b/%b required %0d/%b/%b",
                 cmd_code, light_on, fan_on, e.code, e.light, e.fan);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_double();
    test_triple();
    test_refractory();
    test_boundary();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
